// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide unit with pipeline stall
//
// Purpose: accepts one M-extension op, iterates a shift-add multiplier or a
// restoring divider for D_WIDTH cycles, stalls the pipeline meanwhile and
// returns the result with a one-cycle done pulse.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         launch request (sampled only in IDLE)
//   funct3        0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op_a, op_b    rs1 / rs2 operand values
//   kill          abort current or pending op
//   busy          unit not idle
//   stall         freeze fetch/decode while an op is launching or running
//   done          one-cycle result-valid pulse
//   result        final value, held until the next accepted start

module muldiv_sequencer #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] op_a,
    input  logic [D_WIDTH-1:0] op_b,
    input  logic               kill,
    output logic               busy,
    output logic               stall,
    output logic               done,
    output logic [D_WIDTH-1:0] result
);

    localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(D_WIDTH - 1);
    localparam logic [D_WIDTH-1:0] MIN_NEG  = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    // acc/lo form the product register for MUL* and remainder/quotient for DIV*.
    // m holds the multiplicand or divisor magnitude.
    logic [2:0]         f3_q;
    logic               neg_q;
    logic [CW-1:0]      cnt_q;
    logic [D_WIDTH-1:0] acc_q, lo_q, m_q, res_q;

    logic               launch, is_div, a_signed, b_signed, a_neg, b_neg;
    logic               div_zero, div_ovf;
    logic [D_WIDTH-1:0] a_mag, b_mag;

    assign launch   = (state == IDLE) && start && !kill;
    assign is_div   = funct3[2];
    assign a_signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3[2] && !funct3[0]);
    assign b_signed = (funct3 == 3'd1) || (funct3[2] && !funct3[0]);
    assign a_neg    = a_signed && op_a[D_WIDTH-1];
    assign b_neg    = b_signed && op_b[D_WIDTH-1];
    assign a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    assign div_zero = (op_b == '0);
    assign div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (product LSB) is set, then shift the whole product right.
    logic [D_WIDTH:0]     mul_sum;
    logic [2*D_WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, lo_q[D_WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the trial difference only when it does not go negative.
    logic [D_WIDTH:0] rem_shift, rem_diff;
    logic             q_bit;
    assign rem_shift = {acc_q, lo_q[D_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, m_q};
    assign q_bit     = !rem_diff[D_WIDTH];

    // Sign fix-up and result selection
    logic [2*D_WIDTH-1:0] prod_fix;
    logic [D_WIDTH-1:0]   quo_fix, rem_fix, res_comb;
    assign prod_fix = neg_q ? (~{acc_q, lo_q} + 1'b1) : {acc_q, lo_q};
    assign quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    assign rem_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;

    always_comb begin
        res_comb = '0;
        case (f3_q)
            3'd0:             res_comb = prod_fix[D_WIDTH-1:0];
            3'd1, 3'd2, 3'd3: res_comb = prod_fix[2*D_WIDTH-1:D_WIDTH];
            3'd4, 3'd5:       res_comb = quo_fix;
            default:          res_comb = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (launch) state_n = (is_div && (div_zero || div_ovf)) ? DONE : RUN;
            RUN: begin
                if (kill)                   state_n = IDLE;
                else if (cnt_q == LAST_CNT) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q  <= '0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            res_q <= '0;
        end else begin
            if (launch) begin
                f3_q  <= funct3;
                cnt_q <= '0;
                if (is_div && div_zero) begin
                    // quotient all ones, remainder = op_a (magnitude re-signed at fix-up)
                    lo_q  <= '1;
                    acc_q <= a_mag;
                    m_q   <= '0;
                    neg_q <= funct3[1] && a_neg;
                end else if (div_ovf) begin
                    lo_q  <= MIN_NEG;
                    acc_q <= '0;
                    m_q   <= '0;
                    neg_q <= 1'b0;
                end else begin
                    acc_q <= '0;
                    lo_q  <= is_div ? a_mag : b_mag;
                    m_q   <= is_div ? b_mag : a_mag;
                    // remainder sign follows the dividend only
                    neg_q <= (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
                end
            end else if (state == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (f3_q[2]) begin
                    acc_q <= q_bit ? rem_diff[D_WIDTH-1:0] : rem_shift[D_WIDTH-1:0];
                    lo_q  <= {lo_q[D_WIDTH-2:0], q_bit};
                end else begin
                    {acc_q, lo_q} <= mul_next;
                end
            end
            if (state == DONE) res_q <= res_comb;
        end
    end

    assign busy   = (state != IDLE);
    assign stall  = launch || (state == RUN);
    assign done   = (state == DONE);
    assign result = (state == DONE) ? res_comb : res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer

module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    funct3 = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          kill = 1'b0;
    logic          busy, stall, done;
    logic [W-1:0]  result;

    muldiv_sequencer #(.D_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .kill(kill),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
        return W + 1;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected op.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    task automatic push_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int c0);
        exp_t e;
        e.res = ref_model(f3, a, b);
        e.cyc = c0 + latency(f3, a, b);
        exp_q.push_back(e);
    endtask

    // Launch one op from IDLE, follow it to its done cycle, check stall profile.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int n, lat, stall_cnt;
        @(negedge clk);
        chk("result_held", result, last_res);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        lat = latency(f3, a, b);
        push_exp(f3, a, b, cyc);
        #1;
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (stall) stall_cnt++;
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        chk("stall_cycles", 32'(stall_cnt), 32'(lat));
        chk("stall_low_in_done", {31'b0, stall}, 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] ra, rb;
    logic [31:0] specials [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        // Directed ops
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        do_op(3'd1, MIN, MIN);
        do_op(3'd3, MIN, MIN);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
        do_op(3'd5, 32'd5, 32'd0);
        do_op(3'd6, 32'd5, 32'd0);
        do_op(3'd6, 32'hFFFF_FFFB, 32'd0);
        do_op(3'd4, MIN, 32'hFFFF_FFFF);
        do_op(3'd6, MIN, 32'hFFFF_FFFF);

        // kill at cycle 10 of a DIV
        begin
            int c0;
            @(negedge clk);
            start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; c0 = cyc;
            @(negedge clk);
            start = 1'b0;
            while (cyc < c0 + 10) @(negedge clk);
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            chk("kill_busy", {31'b0, busy}, 32'd0);
            wait_cycles(40);
            chk("kill_result_kept", result, last_res);
        end

        // start and kill together in IDLE
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
        #1;
        chk("startkill_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("startkill_busy", {31'b0, busy}, 32'd0);
        wait_cycles(3);

        // rst mid-RUN
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_cycles(5);
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;

        // start pulsed during RUN is ignored
        begin
            int c0;
            @(negedge clk);
            start = 1'b1; funct3 = 3'd5; op_a = 32'd77; op_b = 32'd5; c0 = cyc;
            push_exp(3'd5, 32'd77, 32'd5, c0);
            @(negedge clk);
            start = 1'b0;
            wait_cycles(5);
            start = 1'b1; funct3 = 3'd0; op_a = 32'd2; op_b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            wait_cycles(45);
        end

        // start held through DONE: second op launches the cycle after DONE
        begin
            int c0, n;
            @(negedge clk);
            start = 1'b1; funct3 = 3'd3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; c0 = cyc;
            push_exp(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, c0);
            n = 0;
            while (!done && n < 100) begin @(negedge clk); n++; end
            funct3 = 3'd7; op_a = 32'd12345; op_b = 32'd67;
            push_exp(3'd7, 32'd12345, 32'd67, cyc + 1);
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!done && n < 100) begin @(negedge clk); n++; end
            if (!done) chk("held_timeout", 32'd0, 32'd1);
        end

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            do_op(3'($urandom_range(0, 7)), ra, rb);
            wait_cycles($urandom_range(0, 2));
        end

        wait_cycles(3);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
